// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, byte-enable patterns.
package mem_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Size 2'b11 behaves as a word, so any size with bit 1 set needs word alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SIZE_HALF)
            mis = addr_lo[0];
        else if (size[1])
            mis = (addr_lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/mem_data_aligner.sv
// Big-endian lane steering: store replication/byte enables and load extraction/extension.
module mem_data_aligner
    import mem_stage_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_se,
    input  logic [31:0] ld_rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_be    = BE_WORD;
        case (st_size)
            SIZE_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = BE_BYTE0 >> st_addr_lo;
            end
            SIZE_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_addr_lo[1] ? BE_HALF_LO : BE_HALF_HI;
            end
            default: begin
                st_wdata = st_data;
                st_be    = BE_WORD;
            end
        endcase
    end

    // Offset 0 is the most significant lane.
    always_comb begin
        ld_byte = ld_rdata[31:24];
        case (ld_addr_lo)
            2'd0: ld_byte = ld_rdata[31:24];
            2'd1: ld_byte = ld_rdata[23:16];
            2'd2: ld_byte = ld_rdata[15:8];
            default: ld_byte = ld_rdata[7:0];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[15:0] : ld_rdata[31:16];

        ld_data = ld_rdata;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_se & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{ld_se & ld_half[15]}}, ld_half};
            default:   ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// SPARC MEM stage: data-memory bus master with alignment check, bus timeout,
// upstream stall generation and the MEM/WB pipeline register.
//
//   state | meaning
//   IDLE  | no bus access outstanding; non-memory ops pass straight to MEM/WB
//   BUSY  | dm_req held, waiting for dm_ack or the timeout
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic        clk,
    input  logic        R,
    input  logic        E_mem,
    input  logic        rw_dm_mem,
    input  logic [1:0]  size_mem,
    input  logic        se_mem,
    input  logic        load_mem,
    input  logic        rf_le_mem,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] alu_out_mem,
    input  logic [31:0] df_a_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [4:0]  wb_rd,
    output logic        wb_rf_le,
    output logic [31:0] wb_data
);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            dm_req_q, dm_req_d;
    logic            dm_we_q, dm_we_d;
    logic [31:0]     dm_addr_q, dm_addr_d;
    logic [31:0]     dm_wdata_q, dm_wdata_d;
    logic [3:0]      dm_be_q, dm_be_d;
    logic            fault_q, fault_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_rf_le_q, wb_rf_le_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [1:0]      lat_addr_lo_q, lat_addr_lo_d;
    logic [1:0]      lat_size_q, lat_size_d;
    logic            lat_se_q, lat_se_d;

    logic            misaligned;
    logic            timeout_hit;
    logic [31:0]     st_wdata;
    logic [3:0]      st_be;
    logic [31:0]     ld_data;

    assign misaligned  = E_mem && is_misaligned(size_mem, alu_out_mem[1:0]);
    assign timeout_hit = (state_q == BUSY) && !dm_ack
                         && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Load formatting uses the request-time size/offset/sign, not the live inputs.
    mem_data_aligner u_aligner (
        .st_size    (size_mem),
        .st_addr_lo (alu_out_mem[1:0]),
        .st_data    (df_a_mem),
        .ld_size    (lat_size_q),
        .ld_addr_lo (lat_addr_lo_q),
        .ld_se      (lat_se_q),
        .ld_rdata   (dm_rdata),
        .st_wdata   (st_wdata),
        .st_be      (st_be),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dm_req_q      <= 1'b0;
            dm_we_q       <= 1'b0;
            dm_addr_q     <= '0;
            dm_wdata_q    <= '0;
            dm_be_q       <= '0;
            fault_q       <= 1'b0;
            wb_rd_q       <= '0;
            wb_rf_le_q    <= 1'b0;
            wb_data_q     <= '0;
            lat_addr_lo_q <= '0;
            lat_size_q    <= '0;
            lat_se_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dm_req_q      <= dm_req_d;
            dm_we_q       <= dm_we_d;
            dm_addr_q     <= dm_addr_d;
            dm_wdata_q    <= dm_wdata_d;
            dm_be_q       <= dm_be_d;
            fault_q       <= fault_d;
            wb_rd_q       <= wb_rd_d;
            wb_rf_le_q    <= wb_rf_le_d;
            wb_data_q     <= wb_data_d;
            lat_addr_lo_q <= lat_addr_lo_d;
            lat_size_q    <= lat_size_d;
            lat_se_q      <= lat_se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (E_mem && !misaligned) state_d = BUSY;
            BUSY:    if (dm_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall     = 1'b0;
        cnt_d         = cnt_q;
        dm_req_d      = dm_req_q;
        dm_we_d       = dm_we_q;
        dm_addr_d     = dm_addr_q;
        dm_wdata_d    = dm_wdata_q;
        dm_be_d       = dm_be_q;
        fault_d       = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_rf_le_d    = wb_rf_le_q;
        wb_data_d     = wb_data_q;
        lat_addr_lo_d = lat_addr_lo_q;
        lat_size_d    = lat_size_q;
        lat_se_d      = lat_se_q;

        case (state_q)
            IDLE: begin
                if (!E_mem || misaligned) begin
                    wb_rd_d    = mem_rd;
                    wb_rf_le_d = rf_le_mem && !misaligned;
                    wb_data_d  = alu_out_mem;
                    fault_d    = misaligned;
                end else begin
                    mem_stall     = 1'b1;
                    dm_req_d      = 1'b1;
                    dm_we_d       = rw_dm_mem;
                    dm_addr_d     = {alu_out_mem[31:2], 2'b00};
                    dm_wdata_d    = st_wdata;
                    dm_be_d       = st_be;
                    cnt_d         = '0;
                    wb_rf_le_d    = 1'b0;
                    lat_addr_lo_d = alu_out_mem[1:0];
                    lat_size_d    = size_mem;
                    lat_se_d      = se_mem;
                end
            end
            BUSY: begin
                if (dm_ack) begin
                    dm_req_d   = 1'b0;
                    wb_rd_d    = mem_rd;
                    wb_rf_le_d = rf_le_mem;
                    wb_data_d  = load_mem ? ld_data : alu_out_mem;
                end else if (timeout_hit) begin
                    dm_req_d   = 1'b0;
                    fault_d    = 1'b1;
                    wb_rf_le_d = 1'b0;
                end else begin
                    mem_stall  = 1'b1;
                    cnt_d      = cnt_q + TO_W'(1);
                    wb_rf_le_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign dm_be     = dm_be_q;
    assign mem_fault = fault_q;
    assign wb_rd     = wb_rd_q;
    assign wb_rf_le  = wb_rf_le_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// operations checked against a behavioural model of the MEM stage.
module tb_mem_access_stage;

    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        R;
    logic        E_mem, rw_dm_mem, se_mem, load_mem, rf_le_mem;
    logic [1:0]  size_mem;
    logic [4:0]  mem_rd;
    logic [31:0] alu_out_mem, df_a_mem;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_stall, mem_fault, wb_rf_le;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(5)) dut (
        .clk(clk), .R(R), .E_mem(E_mem), .rw_dm_mem(rw_dm_mem), .size_mem(size_mem),
        .se_mem(se_mem), .load_mem(load_mem), .rf_le_mem(rf_le_mem), .mem_rd(mem_rd),
        .alu_out_mem(alu_out_mem), .df_a_mem(df_a_mem), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
        .wb_rd(wb_rd), .wb_rf_le(wb_rf_le), .wb_data(wb_data)
    );

    // ---------------- behavioural model ----------------
    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd1) return (off % 2) != 0;
        if (size >= 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << (3 - off));
        if (size == 2'd1) return (off < 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                           input logic se, input logic [31:0] rdata);
        int     off = int'(addr % 4);
        int     bits;
        longint v;
        if (size == 2'd0) begin
            bits = 8;
            v = longint'((rdata >> (8 * (3 - off))) & 32'hFF);
        end else if (size == 2'd1) begin
            bits = 16;
            v = longint'((rdata >> ((off < 2) ? 16 : 0)) & 32'hFFFF);
        end else begin
            return rdata;
        end
        if (se && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    task automatic drive(input logic e, input logic rw, input logic [1:0] sz, input logic se,
                         input logic ld, input logic rfle, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] d);
        E_mem = e; rw_dm_mem = rw; size_mem = sz; se_mem = se; load_mem = ld;
        rf_le_mem = rfle; mem_rd = rd; alu_out_mem = addr; df_a_mem = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        R = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
        drive(0, 0, 2'd0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_fault, wb_rd, wb_rf_le, wb_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%b fault=%b rd=%0d rfle=%b data=%h, all required 0",
                     dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_fault, wb_rd, wb_rf_le, wb_data);
        end
        n_checks++;
        if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b need 0", mem_stall); end
        R = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive(0, 0, 2'd2, 0, 0, 1, 5'd5, 32'h0000_1234, 32'h0);
        #1;
        n_checks++;
        if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL pass_stall: got %b need 0", mem_stall); end
        @(negedge clk);
        n_checks++;
        if ({wb_data, wb_rd, wb_rf_le} !== {32'h0000_1234, 5'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL pass_wb: data=%h rd=%0d rfle=%b need 00001234/5/1", wb_data, wb_rd, wb_rf_le);
        end
        n_checks++;
        if (dm_req !== 1'b0) begin n_fail++; $display("FAIL pass_req: got %b need 0", dm_req); end
    endtask

    task automatic test_load_byte();
        int stalls = 0;
        drive(1, 0, 2'd0, 1, 1, 1, 5'd7, 32'h0000_0102, 32'h0);
        #1 if (mem_stall) stalls++;
        @(negedge clk);
        n_checks++;
        if ({dm_req, dm_we, dm_addr, dm_be} !== {1'b1, 1'b0, 32'h0000_0100, 4'b0010}) begin
            n_fail++;
            $display("FAIL lb_bus: req=%b we=%b addr=%h be=%b need 1/0/00000100/0010", dm_req, dm_we, dm_addr, dm_be);
        end
        dm_ack = 1'b1; dm_rdata = 32'h1122_8344;
        #1 if (mem_stall) stalls++;
        @(negedge clk);
        dm_ack = 1'b0; E_mem = 1'b0;
        n_checks++;
        if (stalls != 1) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d need 1", stalls); end
        n_checks++;
        if ({wb_data, wb_rd, wb_rf_le, dm_req} !== {32'hFFFF_FF83, 5'd7, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lb_wb: data=%h rd=%0d rfle=%b req=%b need ffffff83/7/1/0", wb_data, wb_rd, wb_rf_le, dm_req);
        end
    endtask

    task automatic test_store_half();
        drive(1, 1, 2'd1, 0, 0, 0, 5'd9, 32'h0000_0206, 32'h0000_BEEF);
        @(negedge clk);
        n_checks++;
        if ({dm_req, dm_we, dm_be, dm_wdata, dm_addr} !== {1'b1, 1'b1, 4'b0011, 32'hBEEF_BEEF, 32'h0000_0204}) begin
            n_fail++;
            $display("FAIL sh_bus: req=%b we=%b be=%b wdata=%h addr=%h need 1/1/0011/beefbeef/00000204",
                     dm_req, dm_we, dm_be, dm_wdata, dm_addr);
        end
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0; E_mem = 1'b0;
        n_checks++;
        if ({wb_rf_le, dm_req, mem_fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL sh_done: rfle=%b req=%b fault=%b need 0/0/0", wb_rf_le, dm_req, mem_fault);
        end
    endtask

    task automatic test_misaligned();
        drive(1, 0, 2'd2, 0, 1, 1, 5'd3, 32'h0000_0301, 32'h0);
        #1;
        n_checks++;
        if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b need 0", mem_stall); end
        @(negedge clk);
        E_mem = 1'b0;
        n_checks++;
        if ({mem_fault, dm_req, wb_rf_le} !== 3'b100) begin
            n_fail++;
            $display("FAIL mis_fault: fault=%b req=%b rfle=%b need 1/0/0", mem_fault, dm_req, wb_rf_le);
        end
        @(negedge clk);
        n_checks++;
        if (mem_fault !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: fault=%b need 0", mem_fault); end
    endtask

    task automatic test_timeout();
        int  stalls = 0;
        int  cycles = 1;
        bit  seen = 0;
        drive(1, 0, 2'd2, 0, 1, 1, 5'd4, 32'h0000_0500, 32'h0);
        #1 if (mem_stall) stalls++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_fault) begin seen = 1; break; end
            #1 if (mem_stall) stalls++;
            cycles++;
        end
        E_mem = 1'b0;
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL to_fault: no fault within 40 cycles, need one"); end
        // The access spans the request cycle plus TIMEOUT_CYCLES busy cycles; the last
        // busy cycle releases the stall.
        n_checks++;
        if (cycles != TIMEOUT_CYCLES + 1) begin
            n_fail++; $display("FAIL to_cycles: got %0d need %0d", cycles, TIMEOUT_CYCLES + 1);
        end
        n_checks++;
        if (stalls != TIMEOUT_CYCLES) begin
            n_fail++; $display("FAIL to_stall_cycles: got %0d need %0d", stalls, TIMEOUT_CYCLES);
        end
        n_checks++;
        if ({dm_req, wb_rf_le} !== 2'b00) begin
            n_fail++; $display("FAIL to_bus: req=%b rfle=%b need 0/0", dm_req, wb_rf_le);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_fault, dm_req} !== 2'b00) begin
            n_fail++; $display("FAIL to_idle: fault=%b req=%b need 0/0", mem_fault, dm_req);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 2'd0, 0, 0, 1, 5'd2, 32'h0000_0044, 32'h0);
        @(negedge clk);
        drive(1, 0, 2'd2, 0, 1, 1, 5'd6, 32'h0000_0400, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #3 R = 1'b1;
        #1;
        n_checks++;
        if ({dm_req, wb_rf_le, mem_fault, dm_addr} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL ar_clear: req=%b rfle=%b fault=%b addr=%h need 0/0/0/0", dm_req, wb_rf_le, mem_fault, dm_addr);
        end
        E_mem = 1'b0;
        @(negedge clk);
        R = 1'b0;
        drive(1, 1, 2'd0, 0, 0, 0, 5'd1, 32'h0000_0403, 32'h0000_00A5);
        @(negedge clk);
        n_checks++;
        if ({dm_req, dm_we, dm_be, dm_wdata, dm_addr} !== {2'b11, 4'b0001, 32'hA5A5_A5A5, 32'h0000_0400}) begin
            n_fail++;
            $display("FAIL ar_next: req=%b we=%b be=%b wdata=%h addr=%h need 1/1/0001/a5a5a5a5/00000400",
                     dm_req, dm_we, dm_be, dm_wdata, dm_addr);
        end
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0; E_mem = 1'b0;
        n_checks++;
        if ({dm_req, mem_fault} !== 2'b00) begin
            n_fail++; $display("FAIL ar_done: req=%b fault=%b need 0/0", dm_req, mem_fault);
        end
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        drive(0, 0, 2'd2, 0, 1, 1, 5'd3, 32'h0000_0055, 32'h0);
        dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dm_ack = 1'b0;
        n_checks++;
        if ({wb_data, dm_req, mem_fault} !== {32'h0000_0055, 2'b00}) begin
            n_fail++;
            $display("FAIL ack_idle: data=%h req=%b fault=%b need 00000055/0/0", wb_data, dm_req, mem_fault);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic        e, rw, se, ld, rfle, mis;
            logic [1:0]  sz;
            logic [4:0]  rd;
            logic [31:0] addr, d, rdata, exp_data;
            int          dly;
            e = ($urandom_range(0, 9) < 7); rw = 1'($urandom); se = 1'($urandom);
            ld = 1'($urandom); rfle = 1'($urandom); sz = 2'($urandom);
            rd = 5'($urandom); addr = $urandom; d = $urandom; rdata = $urandom;
            dly = $urandom_range(0, 3);
            mis = e && m_misaligned(sz, addr);
            drive(e, rw, sz, se, ld, rfle, rd, addr, d);
            #1;
            n_checks++;
            if (mem_stall !== (e && !mis)) begin
                n_fail++; $display("FAIL rnd_req_stall[%0d]: got %b need %b", n, mem_stall, e && !mis);
            end
            if (!e || mis) begin
                @(negedge clk);
                n_checks++;
                if ({wb_rd, wb_rf_le, wb_data, mem_fault, dm_req} !== {rd, rfle && !mis, addr, mis, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rnd_idle[%0d]: rd=%0d rfle=%b data=%h fault=%b req=%b need %0d/%b/%h/%b/0",
                             n, wb_rd, wb_rf_le, wb_data, mem_fault, dm_req, rd, rfle && !mis, addr, mis);
                end
            end else begin
                @(negedge clk);
                n_checks++;
                if ({dm_req, dm_we, dm_addr, dm_be} !== {1'b1, rw, addr & 32'hFFFF_FFFC, m_be(sz, addr)}) begin
                    n_fail++;
                    $display("FAIL rnd_bus[%0d]: req=%b we=%b addr=%h be=%b need 1/%b/%h/%b",
                             n, dm_req, dm_we, dm_addr, dm_be, rw, addr & 32'hFFFF_FFFC, m_be(sz, addr));
                end
                if (rw) begin
                    n_checks++;
                    if (dm_wdata !== m_wdata(sz, d)) begin
                        n_fail++; $display("FAIL rnd_wdata[%0d]: got %h need %h", n, dm_wdata, m_wdata(sz, d));
                    end
                end
                for (int w = 0; w < dly; w++) begin
                    #1;
                    n_checks++;
                    if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL rnd_wait_stall[%0d]: got %b need 1", n, mem_stall); end
                    @(negedge clk);
                end
                dm_ack = 1'b1; dm_rdata = rdata;
                #1;
                n_checks++;
                if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rnd_ack_stall[%0d]: got %b need 0", n, mem_stall); end
                @(negedge clk);
                dm_ack = 1'b0;
                exp_data = ld ? m_load(sz, addr, se, rdata) : addr;
                n_checks++;
                if ({dm_req, mem_fault, wb_rd, wb_rf_le, wb_data} !== {2'b00, rd, rfle, exp_data}) begin
                    n_fail++;
                    $display("FAIL rnd_done[%0d]: req=%b fault=%b rd=%0d rfle=%b data=%h need 0/0/%0d/%b/%h",
                             n, dm_req, mem_fault, wb_rd, wb_rf_le, wb_data, rd, rfle, exp_data);
                end
            end
        end
        E_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_async_reset();
        test_ack_idle();
        test_random();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
